// File: rtl/mips_pkg.sv
// Shared datapath widths and instruction field positions for the MIPS pipeline.
// Imported by every stage so field slicing stays consistent.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int IMM_W      = 16;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_reg_file.sv
// 32x32 general register file: two asynchronous read ports, one synchronous write port,
// asynchronous clear, and WB->ID write-through bypass. Register $0 always reads 0.
module id_reg_file
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0]     rd_data1,
  output logic [DATA_W-1:0]     rd_data2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              write_hit;

  assign write_hit = we && (wr_addr != REG_ZERO);

  // Reset wins over a concurrent write, so a write during reset never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Bypass lets a value written back this cycle be seen by ID in the same cycle.
  assign rd_data1 = rst                                ? '0      :
                    (write_hit && rd_addr1 == wr_addr) ? wr_data :
                    (rd_addr1 == REG_ZERO)             ? '0      :
                                                         regs[rd_addr1];

  assign rd_data2 = rst                                ? '0      :
                    (write_hit && rd_addr2 == wr_addr) ? wr_data :
                    (rd_addr2 == REG_ZERO)             ? '0      :
                                                         regs[rd_addr2];

endmodule

// File: rtl/id_decode_stage.sv
// ID stage of the 5-stage MIPS pipeline: register file reads with WB bypass,
// immediate sign extension, branch target computation and early equality flag.
module id_decode_stage
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic [DATA_W-1:0]     instruction,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0]     write_data_reg,
  input  logic [DATA_W-1:0]     pcPlus4,
  output logic [DATA_W-1:0]     inst_extended,
  output logic [DATA_W-1:0]     read_data1_reg,
  output logic [DATA_W-1:0]     read_data2_reg,
  output logic [DATA_W-1:0]     branch_adder_id,
  output logic                  zero
);

  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [IMM_W-1:0]      imm;
  logic                  unused_opcode_bits;

  assign rs_addr = instruction[RS_MSB:RS_LSB];
  assign rt_addr = instruction[RT_MSB:RT_LSB];
  assign imm     = instruction[IMM_MSB:IMM_LSB];

  // Opcode/funct decoding lives in the control unit, not here.
  assign unused_opcode_bits = ^instruction[DATA_W-1:RS_MSB+1];

  id_reg_file u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .we       (RegWrite),
    .wr_addr  (write_reg),
    .wr_data  (write_data_reg),
    .rd_addr1 (rs_addr),
    .rd_addr2 (rt_addr),
    .rd_data1 (read_data1_reg),
    .rd_data2 (read_data2_reg)
  );

  assign inst_extended   = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign branch_adder_id = pcPlus4 + (inst_extended << 2);
  assign zero            = (read_data1_reg == read_data2_reg);

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: stimulus pushes expected outputs from an
// architectural register model; a negedge monitor pops and compares.
module tb_id_decode_stage;

  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic [31:0] instruction;
  logic [4:0]  write_reg;
  logic [31:0] write_data_reg;
  logic [31:0] pcPlus4;
  logic [31:0] inst_extended;
  logic [31:0] read_data1_reg;
  logic [31:0] read_data2_reg;
  logic [31:0] branch_adder_id;
  logic        zero;

  typedef struct {
    logic [31:0] ext;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] br;
    logic        zero;
  } expect_t;

  expect_t     sb [$];
  logic [31:0] gpr [32];
  int          checksTotal  = 0;
  int          checksPassed = 0;

  id_decode_stage dut (
    .clk             (clk),
    .rst             (rst),
    .RegWrite        (RegWrite),
    .instruction     (instruction),
    .write_reg       (write_reg),
    .write_data_reg  (write_data_reg),
    .pcPlus4         (pcPlus4),
    .inst_extended   (inst_extended),
    .read_data1_reg  (read_data1_reg),
    .read_data2_reg  (read_data2_reg),
    .branch_adder_id (branch_adder_id),
    .zero            (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view of a GPR read: reset zeroes everything, $0 is zero,
  // and a pending write-back to the same register is visible immediately.
  function automatic logic [31:0] modelRead(input logic r, input logic we, input logic [4:0] wr,
                                            input logic [31:0] wd, input logic [4:0] a);
    if (r) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (we && wr == a) return wd;
    return gpr[a];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // One transaction per clock: drive just after posedge, monitor samples at negedge,
  // model register state is committed at the following posedge.
  task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wr,
                               input logic [31:0] wd, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [15:0] imm, input logic [31:0] pc);
    expect_t     e;
    logic [31:0] sext;
    rst            = r;
    RegWrite       = we;
    write_reg      = wr;
    write_data_reg = wd;
    pcPlus4        = pc;
    instruction    = {6'($urandom), rs, rt, imm};
    if (r) for (int i = 0; i < 32; i++) gpr[i] = 32'd0;
    sext   = 32'(int'($signed(imm)));
    e.ext  = sext;
    e.br   = pc + 32'(sext * 4);
    e.rd1  = modelRead(r, we, wr, wd, rs);
    e.rd2  = modelRead(r, we, wr, wd, rt);
    e.zero = (e.rd1 == e.rd2);
    sb.push_back(e);
    @(posedge clk);
    if (!r && we && wr != 5'd0) gpr[wr] = wd;
    #1;
  endtask

  always @(negedge clk) begin
    expect_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("inst_extended",   inst_extended,   e.ext);
      checkOutput("read_data1_reg",  read_data1_reg,  e.rd1);
      checkOutput("read_data2_reg",  read_data2_reg,  e.rd2);
      checkOutput("branch_adder_id", branch_adder_id, e.br);
      checkOutput("zero",            {31'd0, zero},   {31'd0, e.zero});
    end
  end

  initial begin
    int waitCycles;
    logic [4:0] lastWr;
    rst = 1'b1; RegWrite = 1'b0; write_reg = '0; write_data_reg = '0;
    instruction = '0; pcPlus4 = '0;
    for (int i = 0; i < 32; i++) gpr[i] = 32'd0;
    @(posedge clk); #1;

    $display("[TB] directed sequence");
    applyStimulus(1, 1, 5'd5, 32'h1111_1111, 5'd5, 5'd9, 16'h0000, 32'h0);
    applyStimulus(0, 1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, 16'hFFFC, 32'h0000_0100);
    applyStimulus(0, 0, 5'd0, 32'h0,         5'd5, 5'd0, 16'h0004, 32'h0000_0100);
    applyStimulus(0, 1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 16'h0000, 32'h0);
    applyStimulus(0, 0, 5'd0, 32'h0,         5'd0, 5'd5, 16'h0000, 32'h0);
    applyStimulus(0, 1, 5'd7, 32'h0000_0042, 5'd7, 5'd7, 16'h0000, 32'h0);
    applyStimulus(0, 0, 5'd0, 32'h0,         5'd7, 5'd8, 16'h0002, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 5'd3, 32'h0000_ABCD, 5'd5, 5'd7, 16'h8000, 32'h0);
    applyStimulus(0, 0, 5'd0, 32'h0,         5'd3, 5'd3, 16'h7FFF, 32'h0);
    applyStimulus(1, 0, 5'd0, 32'h0,         5'd3, 5'd5, 16'h0000, 32'h0);
    applyStimulus(0, 1, 5'd4, 32'h0000_0044, 5'd3, 5'd4, 16'h0000, 32'h0);
    applyStimulus(1, 1, 5'd4, 32'h0000_0099, 5'd4, 5'd4, 16'h0000, 32'h0);
    applyStimulus(0, 0, 5'd0, 32'h0,         5'd4, 5'd0, 16'h0000, 32'h0);

    $display("[TB] random sequence");
    lastWr = 5'd1;
    for (int n = 0; n < 400; n++) begin
      logic r, we;
      logic [4:0] wr, rs, rt;
      r  = ($urandom_range(0, 49) == 0);
      we = ($urandom_range(0, 2) != 0);
      wr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      case ($urandom_range(0, 3))
        0:       rs = wr;
        1:       rs = lastWr;
        default: rs = 5'($urandom);
      endcase
      rt = ($urandom_range(0, 3) == 0) ? rs : 5'($urandom);
      applyStimulus(r, we, wr, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                    rs, rt, 16'($urandom), $urandom);
      if (we) lastWr = wr;
    end

    waitCycles = 0;
    while (sb.size() != 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    if (sb.size() != 0) begin
      checksTotal++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
